// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and timer limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest value the external timer shows before it wraps (59.9 s).
  localparam logic [5:0] MAX_SEC   = 6'd59;
  localparam logic [3:0] MAX_TENTH = 4'd9;

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer plus falling-edge detector for one raw active-low button.
// Latency: press is high in the cycle after the 2nd edge sampling the button low.
// Backpressure: none; one single-cycle press pulse per high-to-low transition.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw button and keep one delayed copy for edge detection;
  // reset parks everything at the released level so no spurious edge appears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Falling edge only: holding the button produces no further pulses.
  assign press = prev & ~sync2;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control FSM: start/pause, lap store/clear and lap recall from three buttons.
// Latency: state/outputs change on the 3rd clk edge after the first edge sampling a press.
// Backpressure: none; events arriving in the same cycle resolve st > lap > rcl, losers dropped.
// Optional STOPWATCH_AUTO_STOP_EN: stop the timer at 59.9 s and park in DONE.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int LAP_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           st_n,
  input  logic                           lap_n,
  input  logic                           rcl_n,
  input  logic [3:0]                     tenth_sec,
  input  logic [5:0]                     sec,
  output logic                           timer_en,
  output logic                           timer_rst,
  output logic                           lap_wr_en,
  output logic [$clog2(LAP_DEPTH)-1:0]   lap_wr_addr,
  output logic [$clog2(LAP_DEPTH)-1:0]   lap_rd_addr,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_full,
  output logic                           view_lap
);

  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic st_ev;
  logic lap_ev;
  logic rcl_ev;

  button_edge u_st_edge  (.clk(clk), .reset(reset), .btn_n(st_n),  .press(st_ev));
  button_edge u_lap_edge (.clk(clk), .reset(reset), .btn_n(lap_n), .press(lap_ev));
  button_edge u_rcl_edge (.clk(clk), .reset(reset), .btn_n(rcl_n), .press(rcl_ev));

  state_t          state_q,   state_d;
  logic [AW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            view_q,    view_d;
  logic            wr_en_q,   wr_en_d;
  logic            trst_q,    trst_d;
  logic            full;
  logic            at_max;
  logic [CW-1:0]   rd_inc;

  assign full = (count_q == CW'(LAP_DEPTH));

`ifdef STOPWATCH_AUTO_STOP_EN
  // Timer is showing its last value while running: stop it this very cycle.
  assign at_max = (state_q == RUN) && (sec == MAX_SEC) && (tenth_sec == MAX_TENTH);
`else
  logic unused_timer_value;
  assign at_max             = 1'b0;
  assign unused_timer_value = ^{sec, tenth_sec};
`endif

  // Register the FSM state, lap bookkeeping and single-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      view_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      trst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      view_q    <= view_d;
      wr_en_q   <= wr_en_d;
      trst_q    <= trst_d;
    end
  end

  // Next-state decode: auto-stop first, then one button event by priority st > lap > rcl.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    view_d    = view_q;
    wr_en_d   = 1'b0;
    trst_d    = 1'b0;
    rd_inc    = CW'(rd_addr_q) + CW'(1);

    // The pointer/count advance the cycle after the strobe, so the strobe
    // carries the slot being written. Once full the pointer reads back 0,
    // which is harmless because full blocks any further write.
    if (wr_en_q) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      count_d  = count_q + CW'(1);
    end

    if (at_max) begin
      state_d = DONE;
    end else if (st_ev) begin
      case (state_q)
        IDLE, PAUSE: begin
          state_d = RUN;
          view_d  = 1'b0;
        end
        RUN:     state_d = PAUSE;
        default: ;
      endcase
    end else if (lap_ev) begin
      case (state_q)
        RUN: begin
          if (!full) wr_en_d = 1'b1;
        end
        PAUSE, DONE: begin
          trst_d    = 1'b1;
          wr_ptr_d  = '0;
          count_d   = '0;
          rd_addr_d = '0;
          view_d    = 1'b0;
          state_d   = IDLE;
        end
        default: ;
      endcase
    end else if (rcl_ev && (state_q != RUN) && (count_q != '0)) begin
      if (!view_q) begin
        view_d    = 1'b1;
        rd_addr_d = '0;
      end else begin
        rd_addr_d = (rd_inc >= count_q) ? '0 : rd_inc[AW-1:0];
      end
    end
  end

  assign timer_en    = (state_q == RUN) && !at_max;
  assign timer_rst   = trst_q;
  assign lap_wr_en   = wr_en_q;
  assign lap_wr_addr = wr_ptr_q;
  assign lap_rd_addr = rd_addr_q;
  assign lap_count   = count_q;
  assign lap_full    = full;
  assign view_lap    = view_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Self-checking bench for stopwatch_sequencer (LAP_DEPTH = 8).
// Directed scenarios plus randomized button presses scored against a behavioural model.
// Honours STOPWATCH_AUTO_STOP_EN when the design is built with it.
module tb_stopwatch_sequencer;

  localparam int D = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st_n = 1'b1, lap_n = 1'b1, rcl_n = 1'b1;
  logic [3:0] tenth_sec = 4'd0;
  logic [5:0] sec = 6'd0;
  logic       timer_en, timer_rst, lap_wr_en, lap_full, view_lap;
  logic [2:0] lap_wr_addr, lap_rd_addr;
  logic [3:0] lap_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the stopwatch as seen from its buttons.
  int m_mode = M_IDLE;
  int m_cnt  = 0;
  int m_rd   = 0;
  bit m_view = 0;
  int exp_wr[$];
  int exp_rst = 0;
  int obs_wr[$];
  int obs_rst = 0;

  stopwatch_sequencer #(.LAP_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .st_n(st_n), .lap_n(lap_n), .rcl_n(rcl_n),
    .tenth_sec(tenth_sec), .sec(sec), .timer_en(timer_en), .timer_rst(timer_rst),
    .lap_wr_en(lap_wr_en), .lap_wr_addr(lap_wr_addr), .lap_rd_addr(lap_rd_addr),
    .lap_count(lap_count), .lap_full(lap_full), .view_lap(view_lap)
  );

  always #5 clk = ~clk;

  // Record every strobe cycle; a stretched strobe shows up as extra entries.
  always @(negedge clk) begin
    if (!reset) begin
      if (lap_wr_en) obs_wr.push_back(int'(lap_wr_addr));
      if (timer_rst) obs_rst++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit s, input bit l, input bit r, input int hold);
    @(negedge clk);
    st_n = !s; lap_n = !l; rcl_n = !r;
    repeat (hold) @(negedge clk);
    st_n = 1'b1; lap_n = 1'b1; rcl_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic model_event(input bit s, input bit l, input bit r);
    if (s) begin
      if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
        m_mode = M_RUN; m_view = 0;
      end else if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (l) begin
      if (m_mode == M_RUN) begin
        if (m_cnt < D) begin exp_wr.push_back(m_cnt); m_cnt++; end
      end else if (m_mode == M_PAUSE || m_mode == M_DONE) begin
        exp_rst++; m_cnt = 0; m_rd = 0; m_view = 0; m_mode = M_IDLE;
      end
    end else if (r) begin
      if (m_mode != M_RUN && m_cnt > 0) begin
        if (!m_view) begin m_view = 1; m_rd = 0; end
        else m_rd = (m_rd + 1) % m_cnt;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_rd = 0; m_view = 0;
    exp_wr.delete(); exp_rst = 0; obs_wr.delete(); obs_rst = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (timer_en !== 1'b0) begin miscompares++; $display("FAIL reset_timer_en got %b want 0", timer_en); end
    vectors++; if (timer_rst !== 1'b0) begin miscompares++; $display("FAIL reset_timer_rst got %b want 0", timer_rst); end
    vectors++; if (lap_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_lap_wr_en got %b want 0", lap_wr_en); end
    vectors++; if (lap_full !== 1'b0 || view_lap !== 1'b0) begin miscompares++; $display("FAIL reset_flags full=%b view=%b want 0 0", lap_full, view_lap); end
    vectors++; if (lap_count !== 4'd0 || lap_wr_addr !== 3'd0 || lap_rd_addr !== 3'd0) begin
      miscompares++; $display("FAIL reset_addrs cnt=%0d wr=%0d rd=%0d want 0 0 0", lap_count, lap_wr_addr, lap_rd_addr);
    end
    // A press made and released entirely inside reset must not leak out.
    st_n = 1'b0;
    repeat (3) @(negedge clk);
    st_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    vectors++; if (timer_en !== 1'b0) begin miscompares++; $display("FAIL reset_press_leak timer_en got %b want 0", timer_en); end
    model_reset();
  endtask

  task automatic test_start_pause();
    @(negedge clk);
    st_n = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      vectors++;
      if (timer_en !== (e >= 3)) begin
        miscompares++; $display("FAIL start_edge%0d timer_en got %b want %b", e, timer_en, (e >= 3));
      end
    end
    st_n = 1'b1;
    repeat (5) @(negedge clk);
    model_event(1, 0, 0);
    vectors++; if (timer_en !== 1'b1) begin miscompares++; $display("FAIL start_hold timer_en got %b want 1", timer_en); end
    press(1, 0, 0, 2); model_event(1, 0, 0);
    vectors++; if (timer_en !== 1'b0) begin miscompares++; $display("FAIL pause timer_en got %b want 0", timer_en); end
  endtask

  task automatic test_lap_fill();
    press(1, 0, 0, 1); model_event(1, 0, 0);
    obs_wr.delete(); exp_wr.delete();
    for (int i = 0; i < 9; i++) begin
      press(0, 1, 0, $urandom_range(1, 4));
      model_event(0, 1, 0);
    end
    vectors++; if (obs_wr.size() != 8) begin miscompares++; $display("FAIL lap_fill_strobes got %0d want 8", obs_wr.size()); end
    for (int i = 0; i < obs_wr.size() && i < 8; i++) begin
      vectors++; if (obs_wr[i] != i) begin miscompares++; $display("FAIL lap_fill_addr[%0d] got %0d want %0d", i, obs_wr[i], i); end
    end
    vectors++; if (lap_count !== 4'd8) begin miscompares++; $display("FAIL lap_fill_count got %0d want 8", lap_count); end
    vectors++; if (lap_full !== 1'b1) begin miscompares++; $display("FAIL lap_fill_full got %b want 1", lap_full); end
    vectors++; if (timer_en !== 1'b1) begin miscompares++; $display("FAIL lap_fill_run timer_en got %b want 1", timer_en); end
    obs_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_clear();
    press(1, 0, 0, 1); model_event(1, 0, 0);
    obs_rst = 0; exp_rst = 0;
    press(0, 1, 0, 3); model_event(0, 1, 0);
    vectors++; if (obs_rst != 1) begin miscompares++; $display("FAIL clear_timer_rst pulses got %0d want 1", obs_rst); end
    vectors++; if (lap_count !== 4'd0 || lap_full !== 1'b0) begin miscompares++; $display("FAIL clear_count cnt=%0d full=%b want 0 0", lap_count, lap_full); end
    vectors++; if (view_lap !== 1'b0 || timer_en !== 1'b0) begin miscompares++; $display("FAIL clear_flags view=%b en=%b want 0 0", view_lap, timer_en); end
    // In IDLE a lap press does nothing (in PAUSE it would clear again).
    press(0, 1, 0, 1); model_event(0, 1, 0);
    vectors++; if (obs_rst != 1 || obs_wr.size() != 0) begin miscompares++; $display("FAIL idle_lap rst=%0d wr=%0d want 1 0", obs_rst, obs_wr.size()); end
    press(1, 0, 0, 1); model_event(1, 0, 0);
    vectors++; if (timer_en !== 1'b1) begin miscompares++; $display("FAIL idle_start timer_en got %b want 1", timer_en); end
  endtask

  task automatic test_recall();
    int want_rd[4];
    want_rd = '{0, 1, 2, 0};
    for (int i = 0; i < 3; i++) begin press(0, 1, 0, 1); model_event(0, 1, 0); end
    press(1, 0, 0, 1); model_event(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      press(0, 0, 1, $urandom_range(1, 5)); model_event(0, 0, 1);
      vectors++;
      if (lap_rd_addr !== 3'(want_rd[i]) || view_lap !== 1'b1) begin
        miscompares++; $display("FAIL recall[%0d] rd=%0d view=%b want %0d 1", i, lap_rd_addr, view_lap, want_rd[i]);
      end
    end
    press(1, 0, 0, 1); model_event(1, 0, 0);
    vectors++; if (view_lap !== 1'b0 || timer_en !== 1'b1) begin miscompares++; $display("FAIL run_clears_view view=%b en=%b want 0 1", view_lap, timer_en); end
    obs_wr.delete(); exp_wr.delete();
  endtask

  task automatic test_simultaneous();
    press(1, 1, 0, 2); model_event(1, 1, 0);
    vectors++; if (timer_en !== 1'b0) begin miscompares++; $display("FAIL simul_pause timer_en got %b want 0", timer_en); end
    vectors++; if (obs_wr.size() != 0 || lap_count !== 4'd3) begin miscompares++; $display("FAIL simul_no_lap strobes=%0d cnt=%0d want 0 3", obs_wr.size(), lap_count); end
  endtask

  task automatic test_auto_stop();
    bit want_en;
    press(1, 0, 0, 1); model_event(1, 0, 0);
`ifdef STOPWATCH_AUTO_STOP_EN
    want_en = 1'b0;
`else
    want_en = 1'b1;
`endif
    @(negedge clk);
    sec = 6'd59; tenth_sec = 4'd9;
    #1;
    vectors++; if (timer_en !== want_en) begin miscompares++; $display("FAIL max_same_cycle timer_en got %b want %b", timer_en, want_en); end
    @(negedge clk);
    sec = 6'd0; tenth_sec = 4'd0;
    #1;
    vectors++; if (timer_en !== want_en) begin miscompares++; $display("FAIL max_next_edge timer_en got %b want %b", timer_en, want_en); end
`ifdef STOPWATCH_AUTO_STOP_EN
    m_mode = M_DONE;
`endif
    press(1, 0, 0, 1); model_event(1, 0, 0);
    vectors++; if (timer_en !== (m_mode == M_RUN)) begin miscompares++; $display("FAIL after_max_st timer_en got %b want %b", timer_en, (m_mode == M_RUN)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      bit s, l, r;
      s = ($urandom % 4) == 0;
      l = ($urandom % 3) == 0;
      r = ($urandom % 2) == 0;
      if (!s && !l) r = 1;
      sec = 6'($urandom_range(0, 58));
      tenth_sec = 4'($urandom_range(0, 9));
      press(s, l, r, $urandom_range(1, 6));
      model_event(s, l, r);
      vectors++;
      if (timer_en !== (m_mode == M_RUN) || lap_count !== 4'(m_cnt) || lap_full !== (m_cnt == D) ||
          view_lap !== m_view || lap_rd_addr !== 3'(m_rd) || lap_wr_addr !== 3'(m_cnt % D)) begin
        miscompares++;
        $display("FAIL rand[%0d] en=%b cnt=%0d full=%b view=%b rd=%0d wr=%0d want %b %0d %b %b %0d %0d",
                 it, timer_en, lap_count, lap_full, view_lap, lap_rd_addr, lap_wr_addr,
                 (m_mode == M_RUN), m_cnt, (m_cnt == D), m_view, m_rd, m_cnt % D);
      end
      vectors++;
      if (obs_wr != exp_wr || obs_rst != exp_rst) begin
        miscompares++;
        $display("FAIL rand_strobes[%0d] wr_pulses=%0d rst_pulses=%0d want %0d %0d", it, obs_wr.size(), obs_rst, exp_wr.size(), exp_rst);
      end
      obs_wr.delete(); exp_wr.delete(); obs_rst = 0; exp_rst = 0;
    end
  endtask

  task automatic test_reset_midpress();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_reset();
    press(1, 0, 0, 1); model_event(1, 0, 0);
    @(negedge clk); lap_n = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); lap_n = 1'b1;
    @(negedge clk); reset = 1'b0; model_reset();
    repeat (8) @(negedge clk);
    vectors++; if (obs_wr.size() != 0 || lap_count !== 4'd0) begin miscompares++; $display("FAIL midpress_abort strobes=%0d cnt=%0d want 0 0", obs_wr.size(), lap_count); end
    vectors++; if (timer_en !== 1'b0) begin miscompares++; $display("FAIL midpress_state timer_en got %b want 0", timer_en); end
  endtask

  initial begin
    test_reset();
    test_start_pause();
    test_lap_fill();
    test_clear();
    test_recall();
    test_simultaneous();
    test_auto_stop();
    test_random();
    test_reset_midpress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
